multi_digit_counter: RTL

MULTI_DIGIT_COUNTER -- requirements
Module: multi_digit_counter

---
 rtl/multi_digit_counter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/multi_digit_counter.sv
// multi_digit_counter
//   Up/down/load counter of DIGITS 4-bit digits, BCD (HEX=0) or hex (HEX=1),
//   stepped once per divided tick, with a multiplexed 7-segment scan output.
// Ports
//   CLK  : system clock, rising edge
//   RST  : asynchronous reset, active low
//   EN   : count enable
//   S    : mode, 00 hold / 01 load / 10 up / 11 down
//   D    : load value, digit 0 in D[3:0]
//   Q    : current count, registered
//   WRAP : one-clock pulse after an up-overflow or down-underflow
//   AN   : active-low one-hot digit enable
//   SEG  : active-low segments, SEG[0]=a .. SEG[6]=g

// One counter digit: next value and carry/borrow out for the selected mode.
module mdc_digit #(
  parameter int HEX = 0
) (
  input  logic [3:0] cur_i,
  input  logic [3:0] ld_i,
  input  logic [1:0] mode_i,
  input  logic       cin_i,   // carry (up) or borrow (down) from lower digit
  output logic [3:0] nxt_o,
  output logic       cout_o
);
  localparam logic [3:0] MAXV = (HEX != 0) ? 4'hF : 4'h9;

  always_comb begin
    nxt_o  = cur_i;
    cout_o = 1'b0;
    case (mode_i)
      2'b01: nxt_o = (HEX == 0 && ld_i > 4'd9) ? 4'd9 : ld_i;
      2'b10: if (cin_i) begin
        if (cur_i == MAXV) begin
          nxt_o  = 4'd0;
          cout_o = 1'b1;
        end else begin
          nxt_o = cur_i + 4'd1;
        end
      end
      2'b11: if (cin_i) begin
        if (cur_i == 4'd0) begin
          nxt_o  = MAXV;
          cout_o = 1'b1;
        end else begin
          nxt_o = cur_i - 4'd1;
        end
      end
      default: ;
    endcase
  end
endmodule

module multi_digit_counter #(
  parameter int DIGITS    = 4,
  parameter int DIV_BITS  = 25,
  parameter int SCAN_BITS = 16,
  parameter int HEX       = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic [1:0]            S,
  input  logic [4*DIGITS-1:0]   D,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  WRAP,
  output logic [DIGITS-1:0]     AN,
  output logic [6:0]            SEG
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  logic [DIV_BITS-1:0]     div_q;
  logic [SCAN_BITS-1:0]    scan_q;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DIGITS-1:0][3:0]  q_q, q_d;
  logic [DIGITS:0]         carry;
  logic                    wrap_q;
  logic [DIGITS-1:0]       an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    tick, upd, scan_adv;

  assign tick     = &div_q;
  assign upd      = EN & tick;
  assign scan_adv = &scan_q;

  // Digit 0 always steps; higher digits step only on carry/borrow.
  assign carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    mdc_digit #(.HEX(HEX)) u_dig (
      .cur_i  (q_q[g]),
      .ld_i   (D[4*g +: 4]),
      .mode_i (S),
      .cin_i  (carry[g]),
      .nxt_o  (q_d[g]),
      .cout_o (carry[g+1])
    );
  end

  function automatic logic [6:0] seg_dec(input logic [3:0] v);
    case (v)
      4'h0: seg_dec = 7'b1000000;
      4'h1: seg_dec = 7'b1111001;
      4'h2: seg_dec = 7'b0100100;
      4'h3: seg_dec = 7'b0110000;
      4'h4: seg_dec = 7'b0011001;
      4'h5: seg_dec = 7'b0010010;
      4'h6: seg_dec = 7'b0000010;
      4'h7: seg_dec = 7'b1111000;
      4'h8: seg_dec = 7'b0000000;
      4'h9: seg_dec = 7'b0010000;
      4'hA: seg_dec = 7'b0001000;
      4'hB: seg_dec = 7'b0000011;
      4'hC: seg_dec = 7'b1000110;
      4'hD: seg_dec = 7'b0100001;
      4'hE: seg_dec = 7'b0000110;
      default: seg_dec = 7'b0001110;
    endcase
  endfunction

  // The scan shows the digit at the current index, then moves on; SEG reads
  // the pre-update count, so a fresh count appears by the next scan step.
  always_comb begin
    idx_d = (idx_q == LAST) ? '0 : idx_q + IW'(1);
    for (int i = 0; i < DIGITS; i++) an_d[i] = (idx_q != IW'(i));
    seg_d = seg_dec(q_q[idx_q]);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      div_q  <= '0;
      scan_q <= '0;
      idx_q  <= '0;
      q_q    <= '0;
      wrap_q <= 1'b0;
      an_q   <= '1;
      seg_q  <= 7'h7F;
    end else begin
      div_q  <= div_q + DIV_BITS'(1);
      scan_q <= scan_q + SCAN_BITS'(1);
      if (upd) q_q <= q_d;
      // Carry out of the top digit only exists in up/down modes.
      wrap_q <= upd & S[1] & carry[DIGITS];
      if (scan_adv) begin
        idx_q <= idx_d;
        an_q  <= an_d;
        seg_q <= seg_d;
      end
    end
  end

  assign Q    = q_q;
  assign WRAP = wrap_q;
  assign AN   = an_q;
  assign SEG  = seg_q;
endmodule
